// File: rtl/seg_disp_ctrl_pkg.sv
// Shared glyph constants, message codes and FSM states for the 7-segment display controller.
// Segments are active-low, bit0 = a ... bit6 = g.
package seg_disp_ctrl_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [6:0] SEG_DASH  = 7'h3f;
    localparam logic [6:0] SEG_UNDER = 7'h77;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_P     = 7'h0c;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2b;
    localparam logic [6:0] SEG_R     = 7'h2f;
    localparam logic [6:0] SEG_F     = 7'h0e;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_I     = 7'h79;
    localparam logic [6:0] SEG_L     = 7'h47;

    typedef enum logic [1:0] {
        MsgOpen = 2'd0,
        MsgErr  = 2'd1,
        MsgFail = 2'd2,
        MsgLock = 2'd3
    } msg_code_e;

    typedef enum logic {
        StEntry = 1'b0,
        StMsg   = 1'b1
    } state_e;

    // Left-justified message text; positions past the text are blank.
    function automatic logic [6:0] msg_glyph(input msg_code_e code, input int unsigned pos);
        logic [6:0] g;
        g = SEG_BLANK;
        case (code)
            MsgOpen: begin
                case (pos)
                    0: g = SEG_O;
                    1: g = SEG_P;
                    2: g = SEG_E;
                    3: g = SEG_N;
                    default: g = SEG_BLANK;
                endcase
            end
            MsgErr: begin
                case (pos)
                    0: g = SEG_E;
                    1: g = SEG_R;
                    2: g = SEG_R;
                    default: g = SEG_BLANK;
                endcase
            end
            MsgFail: begin
                case (pos)
                    0: g = SEG_F;
                    1: g = SEG_A;
                    2: g = SEG_I;
                    3: g = SEG_L;
                    default: g = SEG_BLANK;
                endcase
            end
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_disp_ctrl_glyph_rom.sv
// Combinational BCD to 7-segment map; non-decimal codes render blank.
module seg_glyph_rom
    import seg_disp_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// Display controller: arbitrates keypad entry (digits + blinking cursor) against timed
// status messages and produces six registered per-digit segment patterns.
module seg_disp_ctrl
    import seg_disp_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BLINK_HZ = 2,
    parameter int unsigned MSG_MS   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] entry_digits,
    input  logic [2:0]  entry_len,
    input  logic        entry_mask,
    input  logic        msg_req,
    input  logic [1:0]  msg_code,
    output logic        msg_ack,
    output logic        msg_busy,
    output logic [6:0]  seg_data_0,
    output logic [6:0]  seg_data_1,
    output logic [6:0]  seg_data_2,
    output logic [6:0]  seg_data_3,
    output logic [6:0]  seg_data_4,
    output logic [6:0]  seg_data_5
);

    localparam logic [31:0] BlinkCnt = 32'(CLK_FREQ / (2 * BLINK_HZ) - 1);
    localparam logic [31:0] MsgCnt   = 32'((CLK_FREQ / 1000) * MSG_MS - 1);

    state_e      state_q, state_d;
    msg_code_e   code_q, code_d;
    logic [31:0] timer_q, timer_d;
    logic        ack_q, ack_d;
    logic        busy_q;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic [2:0]  len_q;
    logic [6:0]  seg_q [6];
    logic [6:0]  seg_d [6];
    logic [6:0]  glyph [6];
    logic [2:0]  n;

    for (genvar g = 0; g < 6; g++) begin : gen_rom
        seg_glyph_rom u_rom (
            .bcd_i (entry_digits[4*g +: 4]),
            .seg_o (glyph[g])
        );
    end

    // A new request always wins, including on the timeout cycle.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        timer_d = timer_q;
        ack_d   = 1'b0;
        if (msg_req) begin
            state_d = StMsg;
            code_d  = msg_code_e'(msg_code);
            timer_d = MsgCnt;
            ack_d   = 1'b1;
        end else if (state_q == StMsg) begin
            if (timer_q == 32'd0) begin
                state_d = StEntry;
            end else begin
                timer_d = timer_q - 32'd1;
            end
        end
    end

    // A change in entry length restarts the blink so the cursor appears at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_d     = blink_q;
        if (entry_len != len_q) begin
            blink_cnt_d = 32'd0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BlinkCnt) begin
            blink_cnt_d = 32'd0;
            blink_d     = ~blink_q;
        end
    end

    assign n = (entry_len > 3'd6) ? 3'd6 : entry_len;

    // Rendered from next-state values so the display tracks msg_busy cycle for cycle.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            seg_d[i] = SEG_BLANK;
            if (state_d == StMsg) begin
                seg_d[i] = msg_glyph(code_d, i);
            end else if (3'(i) < n) begin
                seg_d[i] = entry_mask ? SEG_DASH : glyph[i];
            end else if (3'(i) == n) begin
                seg_d[i] = blink_d ? SEG_UNDER : SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEntry;
            code_q      <= MsgOpen;
            timer_q     <= 32'd0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b1;
            len_q       <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= SEG_BLANK;
            end
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            busy_q      <= (state_d == StMsg);
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            len_q       <= entry_len;
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    assign msg_ack    = ack_q;
    assign msg_busy   = busy_q;
    assign seg_data_0 = seg_q[0];
    assign seg_data_1 = seg_q[1];
    assign seg_data_2 = seg_q[2];
    assign seg_data_3 = seg_q[3];
    assign seg_data_4 = seg_q[4];
    assign seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Scoreboard bench for seg_disp_ctrl: a behavioural model pushes the expected outputs for
// each clock as stimulus is driven; they are popped and compared after the edge.
module tb_seg_disp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] entry_digits;
    logic [2:0]  entry_len;
    logic        entry_mask;
    logic        msg_req;
    logic [1:0]  msg_code;
    logic        msg_ack;
    logic        msg_busy;
    logic [6:0]  seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [41:0] seg;
        logic        ack;
        logic        busy;
    } exp_t;

    exp_t q[$];

    int   m_state, m_code, m_timer, m_cnt, m_len_prev;
    logic m_phase;

    seg_disp_ctrl #(
        .CLK_FREQ (1000),
        .BLINK_HZ (100),
        .MSG_MS   (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .entry_digits (entry_digits),
        .entry_len    (entry_len),
        .entry_mask   (entry_mask),
        .msg_req      (msg_req),
        .msg_code     (msg_code),
        .msg_ack      (msg_ack),
        .msg_busy     (msg_busy),
        .seg_data_0   (seg_data_0),
        .seg_data_1   (seg_data_1),
        .seg_data_2   (seg_data_2),
        .seg_data_3   (seg_data_3),
        .seg_data_4   (seg_data_4),
        .seg_data_5   (seg_data_5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] b);
        case (b)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic logic [6:0] msg_pat(input int code, input int pos);
        logic [41:0] row;
        case (code)
            0: row = {7'h7f, 7'h7f, 7'h2b, 7'h06, 7'h0c, 7'h40};
            1: row = {7'h7f, 7'h7f, 7'h7f, 7'h2f, 7'h2f, 7'h06};
            2: row = {7'h7f, 7'h7f, 7'h47, 7'h79, 7'h08, 7'h0e};
            default: row = {6{7'h3f}};
        endcase
        return row[7*pos +: 7];
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_code     = 0;
        m_timer    = 0;
        m_cnt      = 0;
        m_phase    = 1'b1;
        m_len_prev = 0;
        q.delete();
    endtask

    task automatic model_push();
        exp_t e;
        int   n;
        n = (entry_len > 3'd6) ? 6 : int'(entry_len);
        e.ack = msg_req;
        if (msg_req) begin
            m_state = 1;
            m_code  = int'(msg_code);
            m_timer = 9;
        end else if (m_state == 1) begin
            if (m_timer == 0) m_state = 0;
            else m_timer--;
        end
        if (int'(entry_len) != m_len_prev) begin
            m_cnt   = 0;
            m_phase = 1'b1;
        end else if (m_cnt == 4) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
        m_len_prev = int'(entry_len);
        e.busy = (m_state == 1);
        for (int i = 0; i < 6; i++) begin
            if (m_state == 1) e.seg[7*i +: 7] = msg_pat(m_code, i);
            else if (i < n) e.seg[7*i +: 7] = entry_mask ? 7'h3f : bcd_glyph(entry_digits[4*i +: 4]);
            else if (i == n) e.seg[7*i +: 7] = m_phase ? 7'h77 : 7'h7f;
            else e.seg[7*i +: 7] = 7'h7f;
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t        e;
        logic [41:0] obs;
        model_push();
        @(posedge clk);
        #1;
        e   = q.pop_front();
        obs = {seg_data_5, seg_data_4, seg_data_3, seg_data_2, seg_data_1, seg_data_0};
        chk("ack", {6'd0, msg_ack}, {6'd0, e.ack});
        chk("busy", {6'd0, msg_busy}, {6'd0, e.busy});
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seg%0d", i), obs[7*i +: 7], e.seg[7*i +: 7]);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_s0"}, seg_data_0, 7'h7f);
        chk({tag, "_s1"}, seg_data_1, 7'h7f);
        chk({tag, "_s2"}, seg_data_2, 7'h7f);
        chk({tag, "_s3"}, seg_data_3, 7'h7f);
        chk({tag, "_s4"}, seg_data_4, 7'h7f);
        chk({tag, "_s5"}, seg_data_5, 7'h7f);
        chk({tag, "_busy"}, {6'd0, msg_busy}, 7'd0);
        chk({tag, "_ack"}, {6'd0, msg_ack}, 7'd0);
    endtask

    initial begin
        rst          = 1'b1;
        entry_digits = 24'h0;
        entry_len    = 3'd0;
        entry_mask   = 1'b0;
        msg_req      = 1'b0;
        msg_code     = 2'd0;
        #12;
        chk_blank("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Empty entry: cursor blinks on digit 0.
        repeat (12) step();

        // Three entered digits with cursor on digit 3.
        entry_digits = 24'h000321;
        entry_len    = 3'd3;
        repeat (12) step();
        chk("entry_d0", seg_data_0, 7'h79);
        chk("entry_d2", seg_data_2, 7'h30);

        // Masked, then full, then over-length entry.
        entry_mask = 1'b1;
        repeat (6) step();
        chk("mask_d1", seg_data_1, 7'h3f);
        entry_len = 3'd6;
        repeat (6) step();
        chk("full_d5", seg_data_5, 7'h3f);
        entry_len = 3'd7;
        repeat (6) step();

        // Single Err message then return to entry.
        entry_mask = 1'b0;
        entry_len  = 3'd3;
        repeat (3) step();
        msg_code = 2'd1;
        msg_req  = 1'b1;
        step();
        msg_req = 1'b0;
        repeat (14) step();

        // Preemption at message cycle 5, then a request on the timeout cycle.
        msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        repeat (4) step();
        msg_code = 2'd0;
        msg_req  = 1'b1;
        step();
        msg_req = 1'b0;
        chk("preempt_d3", seg_data_3, 7'h2b);
        for (int k = 0; k < 20; k++) begin
            if (m_state == 1 && m_timer == 0) break;
            step();
        end
        msg_code = 2'd2;
        msg_req  = 1'b1;
        step();
        msg_req = 1'b0;
        repeat (14) step();

        // Reset in the middle of a lockout message.
        msg_code = 2'd3;
        msg_req  = 1'b1;
        step();
        msg_req = 1'b0;
        repeat (3) step();
        chk("lock_d4", seg_data_4, 7'h3f);
        #2;
        rst = 1'b1;
        #1;
        chk_blank("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
